// File: rtl/sdspi_bench_sequencer_pkg.sv
// sdspi_bench_pkg: shared widths, FSM state encoding and result record for the sdspi bench sequencer.
package sdspi_bench_pkg;
   localparam int N_BLOCK_SIZE    = 32;
   localparam int SCLK_SPEED_SIZE = 5;
   localparam int CMD18_SIZE      = 1;
   localparam int CNT_W           = 40;
   typedef enum logic [2:0] {IDLE, RST, START, WAIT, REPORT, NEXT, DONE} state_t;
   typedef struct packed {
      logic [SCLK_SPEED_SIZE-1:0] speed;
      logic [CMD18_SIZE-1:0]      cmd18;
      logic [CNT_W-1:0]           cycles;
      logic                       timeout;
   } result_t;
endpackage

// File: rtl/sdspi_bench_sequencer_sat_cycle_counter.sv
// sat_cycle_counter: clearable, enabled up-counter that sticks at all-ones and flags it.
module sat_cycle_counter #(
   parameter int W = 40
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         terminal
);
   assign terminal = &count;
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else if (clear) count <= '0;
      else if (en && !terminal) count <= count + W'(1);
endmodule

// File: rtl/sdspi_bench_sequencer.sv
// sdspi_bench_sequencer: sweeps sdspi_system over sclk speeds and cmd18, timing each run.
// Optional watchdog on a hung UUT is built when SDSPI_SEQ_TIMEOUT_EN is defined.
module sdspi_bench_sequencer
   import sdspi_bench_pkg::*;
#(
`ifdef SDSPI_SEQ_TIMEOUT_EN
   parameter longint unsigned TIMEOUT_CYC = 64'hFFFF_FFFF,
`endif
   parameter int RST_CYCLES = 16
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       run,
   input  logic                       sweep_cmd18,
   input  logic [N_BLOCK_SIZE-1:0]    n_blocks_i,
   input  logic [SCLK_SPEED_SIZE-1:0] speed_min,
   input  logic [SCLK_SPEED_SIZE-1:0] speed_max,
   output logic                       uut_rst,
   output logic                       uut_start,
   output logic [N_BLOCK_SIZE-1:0]    uut_n_blocks,
   output logic [SCLK_SPEED_SIZE-1:0] uut_sclk_speed,
   output logic [CMD18_SIZE-1:0]      uut_cmd18,
   input  logic                       uut_finish,
   output logic                       uut_ctrl_mux,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [SCLK_SPEED_SIZE-1:0] res_speed,
   output logic [CMD18_SIZE-1:0]      res_cmd18,
   output logic [CNT_W-1:0]           res_cycles,
   output logic                       res_timeout,
   output logic                       busy,
   output logic                       done
);
   localparam int RC_W = $clog2(RST_CYCLES + 1);
   state_t                     state;
   result_t                    res;
   logic [RC_W-1:0]            rst_cnt;
   logic [SCLK_SPEED_SIZE-1:0] smin, smax;
   logic                       sweep;
   logic [CNT_W-1:0]           count;
   logic                       terminal;
   sat_cycle_counter #(.W(CNT_W)) u_cnt (
      .clk(clk),
      .rst(rst),
      .clear(state == START),
      .en(state == WAIT && !uut_finish && !terminal),
      .count(count),
      .terminal(terminal)
   );
   assign res_speed   = res.speed;
   assign res_cmd18   = res.cmd18;
   assign res_cycles  = res.cycles;
   assign res_timeout = res.timeout;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state          <= IDLE;
         uut_rst        <= 1'b1;
         uut_start      <= 1'b0;
         uut_ctrl_mux   <= 1'b0;
         res_valid      <= 1'b0;
         done           <= 1'b0;
         busy           <= 1'b0;
         uut_n_blocks   <= '0;
         uut_sclk_speed <= '0;
         uut_cmd18      <= '0;
         res            <= '0;
         rst_cnt        <= '0;
         smin           <= '0;
         smax           <= '0;
         sweep          <= 1'b0;
      end else begin
         uut_start <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: if (run) begin
               uut_n_blocks <= n_blocks_i;
               smin         <= speed_min;
               smax         <= speed_max;
               sweep        <= sweep_cmd18;
               busy         <= 1'b1;
               if (speed_min <= speed_max) begin
                  uut_sclk_speed <= speed_min;
                  uut_cmd18      <= '0;
                  uut_ctrl_mux   <= 1'b1;
                  rst_cnt        <= '0;
                  state          <= RST;
               end else begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            RST: begin
               rst_cnt <= rst_cnt + RC_W'(1);
               if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                  uut_rst   <= 1'b0;
                  uut_start <= 1'b1;
                  state     <= START;
               end
            end
            START: state <= WAIT;
            WAIT: if (uut_finish) begin
               res          <= '{speed: uut_sclk_speed, cmd18: uut_cmd18, cycles: count, timeout: 1'b0};
               res_valid    <= 1'b1;
               uut_ctrl_mux <= 1'b0;
               state        <= REPORT;
            end
`ifdef SDSPI_SEQ_TIMEOUT_EN
            else if (count == CNT_W'(TIMEOUT_CYC)) begin
               res          <= '{speed: uut_sclk_speed, cmd18: uut_cmd18, cycles: CNT_W'(TIMEOUT_CYC), timeout: 1'b1};
               res_valid    <= 1'b1;
               uut_ctrl_mux <= 1'b0;
               state        <= REPORT;
            end
`endif
            REPORT: if (res_ready) begin
               res_valid <= 1'b0;
               state     <= NEXT;
            end
            // compare before incrementing so an all-ones speed_max cannot wrap
            NEXT: if (uut_sclk_speed < smax) begin
               uut_sclk_speed <= uut_sclk_speed + SCLK_SPEED_SIZE'(1);
               uut_rst        <= 1'b1;
               uut_ctrl_mux   <= 1'b1;
               rst_cnt        <= '0;
               state          <= RST;
            end else if (uut_cmd18 == '0 && sweep) begin
               uut_cmd18      <= CMD18_SIZE'(1);
               uut_sclk_speed <= smin;
               uut_rst        <= 1'b1;
               uut_ctrl_mux   <= 1'b1;
               rst_cnt        <= '0;
               state          <= RST;
            end else begin
               done    <= 1'b1;
               uut_rst <= 1'b1;
               state   <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_sdspi_bench_sequencer.sv
// tb_sdspi_bench_sequencer: directed sweeps against a behavioural UUT that finishes a set delay after start.
module tb_sdspi_bench_sequencer;
   import sdspi_bench_pkg::*;
   logic clk = 1'b0, rst = 1'b1, run = 1'b0, sweep_cmd18 = 1'b0, res_ready = 1'b1, uut_finish = 1'b0;
   logic [N_BLOCK_SIZE-1:0] n_blocks_i = '0, uut_n_blocks;
   logic [SCLK_SPEED_SIZE-1:0] speed_min = '0, speed_max = '0, uut_sclk_speed, res_speed;
   logic [CMD18_SIZE-1:0] uut_cmd18, res_cmd18;
   logic [CNT_W-1:0] res_cycles;
   logic uut_rst, uut_start, uut_ctrl_mux, res_valid, res_timeout, busy, done;
   int checks = 0, errors = 0;
   int starts = 0, dones = 0, rst_mux = 0;
   int fin_delay = 0, k = 0;
   bit armed = 0;
   logic [46:0] rq[$];

   sdspi_bench_sequencer #(
`ifdef SDSPI_SEQ_TIMEOUT_EN
      .TIMEOUT_CYC(1000),
`endif
      .RST_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst), .run(run), .sweep_cmd18(sweep_cmd18), .n_blocks_i(n_blocks_i),
      .speed_min(speed_min), .speed_max(speed_max), .uut_rst(uut_rst), .uut_start(uut_start),
      .uut_n_blocks(uut_n_blocks), .uut_sclk_speed(uut_sclk_speed), .uut_cmd18(uut_cmd18),
      .uut_finish(uut_finish), .uut_ctrl_mux(uut_ctrl_mux), .res_valid(res_valid), .res_ready(res_ready),
      .res_speed(res_speed), .res_cmd18(res_cmd18), .res_cycles(res_cycles), .res_timeout(res_timeout),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // UUT model: finish is high in the cycle fin_delay cycles after the start cycle
   always @(negedge clk) begin
      if (uut_start) begin armed = 1; k = 0; end
      else if (armed) k++;
      uut_finish = armed && fin_delay != 0 && k == fin_delay;
      if (uut_finish) armed = 0;
      if (res_valid && res_ready) rq.push_back({res_speed, res_cmd18, res_cycles, res_timeout});
      if (uut_start) starts++;
      if (done) dones++;
      if (uut_rst && uut_ctrl_mux) rst_mux++;
   end

   function automatic logic [46:0] pk(int s, int c, longint cy, bit t);
      return {SCLK_SPEED_SIZE'(s), CMD18_SIZE'(c), CNT_W'(cy), t};
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      rq.delete();
      starts = 0; dones = 0; rst_mux = 0;
   endtask

   task automatic go(int mn, int mx, bit sw);
      speed_min = SCLK_SPEED_SIZE'(mn);
      speed_max = SCLK_SPEED_SIZE'(mx);
      sweep_cmd18 = sw;
      run = 1'b1;
      @(posedge clk); #1;
      run = 1'b0;
   endtask

   task automatic wait_done(string tag, int lim);
      int c = 0;
      while (dones == 0 && c < lim) begin @(posedge clk); #1; c++; end
      repeat (3) begin @(posedge clk); #1; end
      chk({tag, "_done_count"}, 64'(dones), 1);
      chk({tag, "_busy_after"}, 64'(busy), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_uut_rst", 64'(uut_rst), 1);
      chk("rst_uut_start", 64'(uut_start), 0);
      chk("rst_mux", 64'(uut_ctrl_mux), 0);
      chk("rst_res_valid", 64'(res_valid), 0);
      chk("rst_done_busy", 64'({done, busy}), 0);
      chk("rst_outputs", 64'({uut_sclk_speed, uut_cmd18, res_cycles[15:0]}), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1) three speeds, 100-cycle UUT
      clr(); fin_delay = 100; n_blocks_i = 32'h1234; res_ready = 1'b1;
      go(2, 4, 0);
      chk("t1_busy", 64'(busy), 1);
      wait_done("t1", 2000);
      chk("t1_nres", 64'(rq.size()), 3);
      for (int i = 0; i < 3; i++) chk($sformatf("t1_res%0d", i), 64'(rq[i]), 64'(pk(2 + i, 0, 99, 0)));
      chk("t1_starts", 64'(starts), 3);
      chk("t1_rst_cycles", 64'(rst_mux), 48);
      chk("t1_n_blocks", 64'(uut_n_blocks), 64'h1234);
      chk("t1_idle_uut_rst", 64'(uut_rst), 1);

      // 2) cmd18 sweep, finish in first WAIT cycle
      clr(); fin_delay = 1;
      go(0, 1, 1);
      wait_done("t2", 2000);
      chk("t2_nres", 64'(rq.size()), 4);
      chk("t2_res0", 64'(rq[0]), 64'(pk(0, 0, 0, 0)));
      chk("t2_res1", 64'(rq[1]), 64'(pk(1, 0, 0, 0)));
      chk("t2_res2", 64'(rq[2]), 64'(pk(0, 1, 0, 0)));
      chk("t2_res3", 64'(rq[3]), 64'(pk(1, 1, 0, 0)));

      // 3) empty range
      clr();
      go(5, 3, 0);
      chk("t3_done_hi", 64'({done, busy}), 3);
      @(posedge clk); #1;
      chk("t3_done_lo", 64'({done, busy}), 0);
      repeat (3) begin @(posedge clk); #1; end
      chk("t3_no_results", 64'(rq.size()), 0);
      chk("t3_no_start", 64'(starts), 0);
      chk("t3_dones", 64'(dones), 1);

      // 4) back-pressure in REPORT
      begin
         logic [46:0] snap;
         int c = 0, s0;
         bit stable = 1;
         clr(); fin_delay = 10; res_ready = 1'b0;
         go(7, 8, 0);
         while (!res_valid && c < 500) begin @(posedge clk); #1; c++; end
         chk("t4_valid", 64'(res_valid), 1);
         snap = {res_speed, res_cmd18, res_cycles, res_timeout};
         s0 = starts;
         repeat (50) begin
            @(posedge clk); #1;
            if (!res_valid || {res_speed, res_cmd18, res_cycles, res_timeout} !== snap) stable = 0;
         end
         chk("t4_stable", 64'(stable), 1);
         chk("t4_snap", 64'(snap), 64'(pk(7, 0, 9, 0)));
         chk("t4_no_start", 64'(starts - s0), 0);
         chk("t4_mux_off", 64'(uut_ctrl_mux), 0);
         res_ready = 1'b1;
         wait_done("t4", 1000);
         chk("t4_nres", 64'(rq.size()), 2);
         chk("t4_res1", 64'(rq[1]), 64'(pk(8, 0, 9, 0)));
      end

      // 5) UUT never finishes, at the all-ones speed
      clr(); fin_delay = 0;
      go(31, 31, 0);
`ifdef SDSPI_SEQ_TIMEOUT_EN
      wait_done("t5", 3000);
      chk("t5_nres", 64'(rq.size()), 1);
      chk("t5_res", 64'(rq[0]), 64'(pk(31, 0, 1000, 1)));
`else
      repeat (1500) @(posedge clk);
      #1;
      chk("t5_stuck", 64'({busy, res_valid, uut_ctrl_mux}), 64'b101);
      chk("t5_speed", 64'(uut_sclk_speed), 31);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
`endif

      // 7) top speed without a timeout: must stop at 31, not wrap
      clr(); fin_delay = 3;
      go(30, 31, 0);
      wait_done("t7", 1000);
      chk("t7_nres", 64'(rq.size()), 2);
      chk("t7_res0", 64'(rq[0]), 64'(pk(30, 0, 2, 0)));
      chk("t7_res1", 64'(rq[1]), 64'(pk(31, 0, 2, 0)));

      // 6) async reset mid-WAIT, then restart
      clr(); fin_delay = 0;
      go(3, 6, 0);
      repeat (40) begin @(posedge clk); #1; end
      chk("t6_in_wait", 64'({busy, uut_ctrl_mux, uut_rst}), 64'b110);
      chk("t6_speed", 64'(uut_sclk_speed), 3);
      #2 rst = 1'b1;
      #1;
      chk("t6_async", 64'({uut_rst, uut_ctrl_mux, busy}), 64'b100);
      chk("t6_speed_clr", 64'(uut_sclk_speed), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      clr(); fin_delay = 5;
      go(3, 3, 0);
      wait_done("t6", 1000);
      chk("t6_nres", 64'(rq.size()), 1);
      chk("t6_res", 64'(rq[0]), 64'(pk(3, 0, 4, 0)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
